// File: rtl/div_row_sequencer.sv
// div_row_sequencer: feeds one fixed-point divider with a row of LEN numerators that
// share a single denominator, and streams the quotients out with last/error flags.
//
// state  | meaning
// IDLE   | no row in progress, waiting for row_start
// ACCEPT | num_ready high, waiting for the next numerator
// ISSUE  | one-cycle div_start pulse
// WAIT   | divider working, timeout timer counting up
// OUT    | quotient presented, held until q_ready
module div_row_sequencer #(
    parameter int WIDTH   = 32,
    parameter int FBITS   = 4,
    parameter int LEN     = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             row_start,
    input  logic [WIDTH-1:0] den,
    input  logic             num_valid,
    input  logic [WIDTH-1:0] num_data,
    output logic             num_ready,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_done,
    input  logic             div_valid,
    input  logic             div_dbz,
    input  logic [WIDTH-1:0] div_val,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data,
    output logic             q_last,
    output logic             q_err,
    input  logic             q_ready,
    output logic             busy,
    output logic             timeout_err
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] SAT      = '1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEPT = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    // The binary point position belongs to the divider; this block only moves whole words.
    if (FBITS < 0 || FBITS >= WIDTH) begin : g_fbits_unsupported
    end

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_b_q, div_b_d;
    logic [WIDTH-1:0] q_data_q, q_data_d;
    logic             q_err_q, q_err_d;
    logic             q_last_q, q_last_d;
    logic             tmo_q, tmo_d;

    // Next-state logic: row sequencing, divider handshake and result substitution.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        timer_d  = timer_q;
        div_a_d  = div_a_q;
        div_b_d  = div_b_q;
        q_data_d = q_data_q;
        q_err_d  = q_err_q;
        q_last_d = q_last_q;
        tmo_d    = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (row_start) begin
                    div_b_d = den;
                    count_d = '0;
                    tmo_d   = 1'b0;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (num_valid) begin
                    div_a_d = num_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d  = timer_q + TMR_W'(1);
                q_last_d = (count_q == LAST_IDX);
                // A done arriving on the timeout cycle still delivers the real result.
                if (div_done) begin
                    if (div_dbz || !div_valid) begin
                        q_data_d = SAT;
                        q_err_d  = 1'b1;
                    end else begin
                        q_data_d = div_val;
                        q_err_d  = 1'b0;
                    end
                    state_d = S_OUT;
                end else if (timer_q == TMR_LAST) begin
                    q_data_d = SAT;
                    q_err_d  = 1'b1;
                    tmo_d    = 1'b1;
                    state_d  = S_OUT;
                end
            end
            S_OUT: begin
                if (q_ready) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = q_last_q ? S_IDLE : S_ACCEPT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            timer_q  <= '0;
            div_a_q  <= '0;
            div_b_q  <= '0;
            q_data_q <= '0;
            q_err_q  <= 1'b0;
            q_last_q <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            div_a_q  <= div_a_d;
            div_b_q  <= div_b_d;
            q_data_q <= q_data_d;
            q_err_q  <= q_err_d;
            q_last_q <= q_last_d;
            tmo_q    <= tmo_d;
        end
    end

    assign num_ready   = (state_q == S_ACCEPT);
    assign div_start   = (state_q == S_ISSUE);
    assign q_valid     = (state_q == S_OUT);
    assign busy        = (state_q != S_IDLE);
    assign div_a       = div_a_q;
    assign div_b       = div_b_q;
    assign q_data      = q_data_q;
    assign q_err       = q_err_q;
    assign q_last      = q_last_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_div_row_sequencer.sv
// tb_div_row_sequencer: scoreboard bench with a behavioural divider stub.
module tb_div_row_sequencer;

    localparam int WIDTH   = 32;
    localparam int FBITS   = 4;
    localparam int LEN     = 8;
    localparam int TIMEOUT = 64;
    localparam int BOUND   = 3000;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        row_start;
    logic [31:0] den;
    logic        num_valid;
    logic [31:0] num_data;
    logic        num_ready;
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic        div_valid;
    logic        div_dbz;
    logic [31:0] div_val;
    logic        q_valid;
    logic [31:0] q_data;
    logic        q_last;
    logic        q_err;
    logic        q_ready;
    logic        busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t        exp_q[$];
    logic [31:0] cur_den;
    int          row_idx;
    int          starts;
    bit          hang = 0;
    int          rdy_mode = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          gap_max = 0;
    int          last_start_cyc = 0;
    int          last_done_cyc = 0;

    div_row_sequencer #(.WIDTH(WIDTH), .FBITS(FBITS), .LEN(LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .row_start(row_start), .den(den),
        .num_valid(num_valid), .num_data(num_data), .num_ready(num_ready),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_valid(div_valid), .div_dbz(div_dbz), .div_val(div_val),
        .q_valid(q_valid), .q_data(q_data), .q_last(q_last), .q_err(q_err),
        .q_ready(q_ready), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic abort(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound of %0d cycles expired", name, BOUND);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "bench aborted");
    endtask

    // Reference: quotient = (num * 2^FBITS) / den, saturated with error when undefined or too wide.
    function automatic exp_t model(input logic [31:0] n, input logic [31:0] d, input bit tmo,
                                   input bit last);
        exp_t e;
        longint unsigned nn, dd, q;
        e.last = last;
        e.data = '1;
        e.err  = 1'b1;
        if (!tmo && d != 0) begin
            nn = longint'(n);
            dd = longint'(d);
            q  = (nn << FBITS) / dd;
            if (q <= 64'h0000_0000_FFFF_FFFF) begin
                e.data = q[31:0];
                e.err  = 1'b0;
            end
        end
        return e;
    endfunction

    // Divider stub: answers each div_start after a random latency unless told to hang.
    initial begin : divider_stub
        bit          pend = 0;
        int          cnt = 0;
        logic [31:0] cap_a, cap_b;
        longint unsigned full;
        div_done = 0; div_valid = 0; div_dbz = 0; div_val = 0;
        forever begin
            @(negedge clk);
            div_done = 0;
            if (rst) begin
                pend = 0;
                continue;
            end
            if (pend) begin
                if (cnt == 0) begin
                    chk("div_a_held", div_a, cap_a);
                    chk("div_b_held", div_b, cap_b);
                    div_done = 1;
                    if (cap_b == 0) begin
                        div_dbz   = 1;
                        div_valid = 1'($urandom_range(1, 0));
                        div_val   = $urandom;
                    end else begin
                        full      = (longint'(cap_a) << FBITS) / longint'(cap_b);
                        div_dbz   = 0;
                        div_valid = (full[63:32] == 0);
                        div_val   = div_valid ? full[31:0] : $urandom;
                    end
                    pend = 0;
                    last_done_cyc = cyc;
                end else begin
                    cnt--;
                end
            end
            if (div_start) begin
                starts++;
                last_start_cyc = cyc;
                chk("div_b_is_row_den", div_b, cur_den);
                if (!hang) begin
                    pend  = 1;
                    cnt   = $urandom_range(lat_max, lat_min) - 1;
                    cap_a = div_a;
                    cap_b = div_b;
                end
            end
        end
    end

    // Output ready pattern.
    initial begin : ready_driver
        q_ready = 0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       q_ready = 1;
                1:       q_ready = (cyc % 3 == 0);
                default: q_ready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    // Monitor: scoreboard pop on every accepted quotient, plus hold and latency checks.
    initial begin : monitor
        bit          pv = 0, pr = 0;
        logic [31:0] pd;
        logic        pe, pl;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 0;
                continue;
            end
            if (q_valid) begin
                if (!pv) begin
                    if (hang) chk("timeout_latency", 32'(cyc - last_start_cyc), 32'(TIMEOUT + 1));
                    else      chk("done_to_q_valid", 32'(cyc - last_done_cyc), 32'd1);
                end else if (!pr) begin
                    chk("q_data_stall_hold", q_data, pd);
                    chk("q_err_stall_hold", 32'(q_err), 32'(pe));
                    chk("q_last_stall_hold", 32'(q_last), 32'(pl));
                end
                if (q_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_quotient: got %h required none", q_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("q_data", q_data, e.data);
                        chk("q_err", 32'(q_err), 32'(e.err));
                        chk("q_last", 32'(q_last), 32'(e.last));
                    end
                end
            end
            pv = q_valid; pr = q_ready; pd = q_data; pe = q_err; pl = q_last;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_num_ready"}, 32'(num_ready), 0);
        chk({tag, "_div_start"}, 32'(div_start), 0);
        chk({tag, "_q_valid"}, 32'(q_valid), 0);
        chk({tag, "_q_last"}, 32'(q_last), 0);
        chk({tag, "_q_err"}, 32'(q_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
        chk({tag, "_div_a"}, div_a, 0);
        chk({tag, "_div_b"}, div_b, 0);
        chk({tag, "_q_data"}, q_data, 0);
    endtask

    task automatic start_row(input logic [31:0] d);
        den = d;
        row_start = 1;
        cur_den = d;
        row_idx = 0;
        starts = 0;
        @(posedge clk);
        #2;
        row_start = 0;
        den = $urandom;
        chk("busy_after_row_start", 32'(busy), 1);
    endtask

    task automatic send_num(input logic [31:0] x);
        int n = 0;
        int gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
        repeat (gap) begin
            @(posedge clk);
            #2;
        end
        num_valid = 1;
        num_data = x;
        exp_q.push_back(model(x, cur_den, hang, row_idx == LEN - 1));
        row_idx++;
        forever begin
            @(negedge clk);
            if (num_ready) break;
            n++;
            if (n > BOUND) abort("num_handshake");
        end
        @(posedge clk);
        #2;
        num_valid = 0;
        num_data = $urandom;
    endtask

    task automatic wait_row_done();
        int n = 0;
        forever begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
            n++;
            if (n > BOUND) abort("row_completion");
        end
        @(posedge clk);
        #2;
        chk("div_starts_per_row", 32'(starts), 32'(LEN));
        chk("busy_after_row", 32'(busy), 0);
    endtask

    task automatic run_row(input logic [31:0] d, input logic [31:0] nums[LEN]);
        start_row(d);
        for (int i = 0; i < LEN; i++) send_num(nums[i]);
        wait_row_done();
    endtask

    logic [31:0] plan[LEN] = '{32'hA0, 32'h40, 32'h10, 32'h00, 32'h30, 32'h50, 32'h80, 32'h20};
    logic [31:0] nums[LEN];

    initial begin : stimulus
        int n;
        rst = 1; row_start = 0; den = 0; num_valid = 0; num_data = 0; cur_den = 0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst = 0;
        @(posedge clk);
        #2;

        // Nominal row at full throughput.
        rdy_mode = 0; lat_min = 2; lat_max = 2; gap_max = 0;
        run_row(32'h20, plan);
        chk("timeout_err_nominal", 32'(timeout_err), 0);

        // Same row with output stalls, input gaps and varying divider latency.
        rdy_mode = 1; lat_min = 1; lat_max = 5; gap_max = 3;
        run_row(32'h20, plan);

        // Zero denominator: divider dbz drives every quotient.
        for (int i = 0; i < LEN; i++) nums[i] = 32'hA0;
        run_row(32'h00, nums);
        chk("timeout_err_dbz", 32'(timeout_err), 0);

        // Random rows, including overflowing and zero denominators.
        rdy_mode = 2;
        for (int r = 0; r < 5; r++) begin
            logic [31:0] d;
            case ($urandom_range(3, 0))
                0:       d = 0;
                1:       d = $urandom_range(15, 1);
                2:       d = $urandom_range(255, 1);
                default: d = $urandom;
            endcase
            for (int i = 0; i < LEN; i++) nums[i] = (r % 2 == 0) ? $urandom : $urandom_range(4095, 0);
            run_row(d, nums);
        end

        // row_start while busy must not re-sample den.
        rdy_mode = 0; gap_max = 0;
        start_row(32'h20);
        for (int i = 0; i < LEN; i++) begin
            send_num(plan[i]);
            if (i == 3) begin
                den = 32'h40;
                row_start = 1;
                @(posedge clk);
                #2;
                row_start = 0;
                den = $urandom;
            end
        end
        wait_row_done();
        chk("div_b_after_ignored_start", div_b, 32'h20);

        // Divider that never answers: every element times out.
        hang = 1;
        for (int i = 0; i < LEN; i++) nums[i] = $urandom_range(1023, 0);
        run_row(32'h20, nums);
        chk("timeout_err_set", 32'(timeout_err), 1);
        hang = 0;
        start_row(32'h20);
        chk("timeout_err_cleared", 32'(timeout_err), 0);
        for (int i = 0; i < LEN; i++) send_num(plan[i]);
        wait_row_done();

        // Reset while element 3 is waiting on the divider.
        rdy_mode = 0;
        start_row(32'h20);
        for (int i = 0; i < 3; i++) send_num(plan[i]);
        n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > BOUND) abort("drain_before_reset");
        end
        hang = 1;
        send_num(plan[3]);
        repeat (4) @(negedge clk);
        chk("busy_before_reset", 32'(busy), 1);
        #2;
        rst = 1;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        hang = 0;
        @(posedge clk);
        #2;
        rst = 0;
        @(posedge clk);
        #2;
        run_row(32'h20, plan);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_row_sequencer.md
Name: div_row_sequencer

Overview:
- Initiator side of the fixed-point divider start/done handshake (divi, WIDTH/FBITS fixed-point).
- Normalises one attention row: receives a row denominator (softmax sum), then LEN numerators over a valid/ready stream.
- Issues one division per numerator to the divider and streams quotients out with last/error flags.
- Sits between the exp/sum stage and the attention-weight output buffer.

Parameters:
- WIDTH, 32, operand/quotient width; must match divider.
- FBITS, 4, fractional bits; passed through only, no arithmetic on it here.
- LEN, 8, numerators per row (>=1).
- TIMEOUT, 64, max cycles from div_start to div_done before error.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- row_start  in  1  one-cycle pulse; latches den, begins row; ignored while busy=1.
- den  in  WIDTH  row denominator, sampled on accepted row_start.
- num_valid  in  1  numerator available.
- num_data  in  WIDTH  numerator (fixed-point).
- num_ready  out  1  sequencer can accept numerator.
- div_start  out  1  one-cycle divider start pulse.
- div_a  out  WIDTH  dividend to divider (held stable from start to done).
- div_b  out  WIDTH  divisor to divider (= latched den).
- div_done  in  1  divider completion pulse.
- div_valid  in  1  divider result valid (no overflow), sampled with done.
- div_dbz  in  1  divider divide-by-zero, sampled with done.
- div_val  in  WIDTH  divider quotient, sampled with done.
- q_valid  out  1  quotient output valid.
- q_data  out  WIDTH  quotient.
- q_last  out  1  marks LEN-th quotient of the row.
- q_err  out  1  quotient substituted (dbz, overflow or timeout).
- busy  out  1  row in progress.
- timeout_err  out  1  sticky; set on divider timeout, cleared by next accepted row_start.

Behaviour:
- Reset: state IDLE; num_ready, div_start, q_valid, q_last, q_err, busy, timeout_err = 0; div_a, div_b, q_data, element count, timer = 0.
- IDLE: row_start=1 -> latch den into div_b, count=0, clear timeout_err, busy=1, go ACCEPT.
- ACCEPT: num_ready=1; on num_valid&num_ready, load div_a=num_data, go ISSUE. num_ready is 0 in all other states.
- ISSUE: div_start=1 for exactly one cycle, timer=0, go WAIT.
- WAIT: timer increments each cycle. On div_done: capture result, go OUT.
  - div_dbz=1 -> q_data = all ones, q_err=1.
  - div_valid=0 (overflow) -> q_data = all ones, q_err=1.
  - Otherwise q_data=div_val, q_err=0.
  - dbz takes priority; both give the same data.
- WAIT timeout: if timer reaches TIMEOUT without div_done, q_data = all ones, q_err=1, timeout_err=1, go OUT. A late div_done arriving in any state other than WAIT is ignored.
- Zero denominator is not special-cased: den=0 is still issued, and the divider's dbz drives the result.
- OUT: q_valid=1, q_last=(count==LEN-1).
  - q_data, q_last, q_err are held stable while q_valid=1 and q_ready=0.
  - On q_ready: count++. If last, busy=0 and go IDLE; else go ACCEPT.
- Latency: numerator accept -> div_start is 1 cycle; div_done -> q_valid is 1 cycle. Best-case throughput is one element per (divider latency + 3) cycles.
- row_start while busy: ignored; den is not re-sampled.
- Reset mid-row: immediate return to reset values; the partial row is discarded. The divider shares rst.

Test Plan:
- FBITS=4, den=0x20 (2.0), nums 0xA0,0x40,0x10,0x00,0x30,0x50,0x80,0x20 with q_ready=1 -> q_data 0x50,0x20,0x08,0x00,0x18,0x28,0x40,0x10; q_err=0; q_last only on 8th; busy drops after it.
- Same row with q_ready toggling 1-of-3 cycles and num_valid gaps -> identical quotient sequence; q_data stable while stalled; exactly one div_start per element.
- den=0x00, nums=0xA0 -> every quotient 0xFFFFFFFF, q_err=1; timeout_err=0.
- Stub divider that never asserts done, TIMEOUT=64 -> q_valid 65 cycles after div_start with 0xFFFFFFFF, q_err=1, timeout_err=1; the next row_start clears timeout_err.
- Pulse row_start with den=0x40 mid-row -> ignored; remaining quotients still use 0x20.
- Assert rst during WAIT of element 3 -> all outputs 0 asynchronously; a new row after reset produces correct results from element 0.
